delay_meas: RTL
===============

Name: delay_meas

Overview:
Measures the latency, in clk cycles, between a rising edge on a reference pulse and the matching rising edge on its returned, delayed copy. This is the checker end of the programmable delay path: the delay line produces the copy and this block recovers the delay count from it. It runs self-test and calibration of delay paths against a programmed delay value. Both inputs are synchronous to clk; no CDC is performed inside the block.

Parameters:
CNT_W, 5, width of the measured delay count
MAX_DELAY, 31, largest measurable delay in cycles (must be ≤ 2^CNT_W-1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous reset, active low
en  input  1  measurement enable; low forces IDLE and suppresses outputs
start_in  input  1  reference signal; its rising edge starts a measurement
echo_in  input  1  delayed signal; its rising edge ends a measurement
delay_out  output  CNT_W  last measured delay in cycles; held until the next result
meas_valid  output  1  one-cycle pulse when delay_out is updated
timeout  output  1  one-cycle pulse when no echo is seen within MAX_DELAY cycles
busy  output  1  high while in COUNT

Behaviour:
- Reset: one clock and reset. rst_n is synchronous, active low, and sampled on the rising edge of clk. On reset:
  - delay_out=0, meas_valid=0, timeout=0, busy=0.
  - FSM goes to IDLE; cnt=0.
  - Edge-detect registers start_d=0 and echo_d=0.
- Edge detection: rise_x = x_in & ~x_d, where x_d is x_in registered. Both inputs pass through identical detectors, so their relative timing is preserved.
- Definition: S is the clk edge at which start_in is first sampled high; E is the same for echo_in. Result = E − S.
- IDLE (busy=0):
  - rise_start with rise_echo in the same cycle: delay_out<=0, meas_valid<=1, stay in IDLE.
  - rise_start alone: cnt<=1, go to COUNT.
  - rise_echo without rise_start: ignored.
- COUNT (busy=1):
  - rise_echo: delay_out<=cnt, meas_valid<=1, go to IDLE.
  - else if cnt==MAX_DELAY: timeout<=1, go to IDLE; delay_out is unchanged.
  - else cnt<=cnt+1.
  - rise_start while in COUNT is ignored and does not restart the count.
  - rise_start and rise_echo together: the echo completes the current measurement; the new start is dropped.
- Latency: meas_valid is high during the cycle after edge E+1, i.e. registered at edge E+1. timeout is registered at edge S+MAX_DELAY+1.
- meas_valid and timeout are never high together. Each lasts exactly one cycle.
- en low: FSM goes to IDLE and cnt clears at the next edge. meas_valid and timeout are held 0. delay_out keeps its last value. Edge registers keep tracking the inputs, so an input already high when en rises does not count as an edge.
- Reset mid-COUNT: no result and no timeout is emitted; all state clears at the next edge.
- cnt never wraps; the comparison against MAX_DELAY bounds it.

Decomposition:
- Shared package (delay_pkg): FSM state encoding (ST_IDLE, ST_COUNT), default CNT_W, default MAX_DELAY.
- One sub-module, rise_det: a registered rising-edge detector with synchronous active-low reset, instantiated once for start_in and once for echo_in.
- FSM, counter and output registers live in delay_meas. Expected size is about 150 lines of RTL.

Test Plan:
- start_in rises at edge 10, echo_in rises at edge 15 → meas_valid pulses at edge 16 with delay_out=5; busy is high from edge 11 to edge 15.
- start_in and echo_in rise on the same edge 20 → delay_out=0, meas_valid at edge 21, busy stays 0.
- start_in rises at edge 30, echo_in at edge 61 → delay_out=31 with meas_valid. Rerun with echo at edge 62 → timeout pulse at edge 62, no meas_valid, delay_out still 31.
- start_in rises at edge 40; a second start rises at edge 43; echo rises at edge 47 → single result delay_out=7; the second start is ignored.
- start_in rises at edge 50; en drops at edge 53; echo rises at edge 55 → no meas_valid or timeout, and delay_out keeps its prior value. Repeat with rst_n low at edge 53 instead → all outputs are 0 from edge 54.
- echo_in pulses with no start, and start_in is held high continuously → no meas_valid, no timeout, busy stays 0.

Source files
------------

// File: rtl/delay_pkg.sv
// Shared types and defaults for the delay measurement checker.
// Holds the FSM state encoding and default count width / max delay.
package delay_pkg;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_COUNT
  } state_e;

  localparam int CNT_W_DEF     = 5;
  localparam int MAX_DELAY_DEF = 31;

endpackage

// File: rtl/rise_det.sv
// Registered rising-edge detector, synchronous active-low reset.
// Ports: clk, rst_n, x_in (level), rise (one-cycle pulse, registered).
module rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic x_in,
  output logic rise
);

  logic x_q, x_d;
  logic rise_q, rise_d;

  always_comb begin
    x_d    = x_in;
    rise_d = x_in & ~x_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q    <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/delay_meas.sv
// Measures clk cycles between a start_in rising edge and echo_in rising edge.
// Ports: clk, rst_n, en, start_in, echo_in -> delay_out, meas_valid, timeout, busy.
module delay_meas
  import delay_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int MAX_DELAY = MAX_DELAY_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start_in,
  input  logic             echo_in,
  output logic [CNT_W-1:0] delay_out,
  output logic             meas_valid,
  output logic             timeout,
  output logic             busy
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_DELAY);

  logic rise_start, rise_echo;

  rise_det u_start_det (
    .clk  (clk),
    .rst_n(rst_n),
    .x_in (start_in),
    .rise (rise_start)
  );

  rise_det u_echo_det (
    .clk  (clk),
    .rst_n(rst_n),
    .x_in (echo_in),
    .rise (rise_echo)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] delay_q, delay_d;
  logic             mv_q, mv_d;
  logic             to_q, to_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    delay_d = delay_q;
    mv_d    = 1'b0;
    to_d    = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (rise_start && rise_echo) begin
            delay_d = '0;
            mv_d    = 1'b1;
          end else if (rise_start) begin
            cnt_d   = CNT_W'(1);
            state_d = ST_COUNT;
          end
        end
        ST_COUNT: begin
          // Echo wins over a coincident restart; start is never re-armed here.
          if (rise_echo) begin
            delay_d = cnt_q;
            mv_d    = 1'b1;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else if (cnt_q == MAX_C) begin
            to_d    = 1'b1;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    busy_d = (state_d == ST_COUNT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      delay_q <= '0;
      mv_q    <= 1'b0;
      to_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      delay_q <= delay_d;
      mv_q    <= mv_d;
      to_q    <= to_d;
      busy_q  <= busy_d;
    end
  end

  assign delay_out  = delay_q;
  assign meas_valid = mv_q;
  assign timeout    = to_q;
  assign busy       = busy_q;

endmodule
